// File: rtl/aes_mix_columns_engine.sv
// ============================================================================
// aes_mix_columns_engine: AES MixColumns / InvMixColumns, 1/2/4 columns/clk
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_SUPPORT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_STEP   = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] C_LAST   = 2'(4 - COLS_PER_CYCLE);
  localparam logic       C_INV_EN = (INV_SUPPORT != 0);

  state_t         state_q, state_d;
  logic [127:0]   src_q, src_d;
  logic [127:0]   res_q, res_d;
  logic           inv_q, inv_d;
  logic [1:0]     col_q, col_d;
  logic [1:0]     idx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse coefficients are composed from 2x/4x/8x multiples:
  // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] r  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv) begin
        r[i] = (x8[i] ^ x4[i] ^ x2[i])
             ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
             ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
             ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end else begin
        r[i] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    inv_d   = inv_q;
    col_d   = col_q;
    res_d   = res_q;
    idx     = 2'd0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_state;
          inv_d   = in_inverse & C_INV_EN;
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Column c occupies bits [127-32c -: 32], i.e. msb index {~c, 5'h1f}.
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          idx = col_q + 2'(g);
          res_d[{~idx, 5'h1f} -: 32] = mix_col(src_q[{~idx, 5'h1f} -: 32], inv_q);
        end
        col_d = col_q + C_STEP;
        if (col_q == C_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      inv_q   <= 1'b0;
      col_q   <= 2'd0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      inv_q   <= inv_d;
      col_q   <= col_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = res_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_mix_columns_engine.sv
// ============================================================================
// tb_aes_mix_columns_engine: directed + randomized checks against a GF model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_state;
  logic         in_inverse;
  logic         in_valid     [3];
  logic         out_ready    [3];
  logic         in_ready_w   [3];
  logic         out_valid_w  [3];
  logic         busy_w       [3];
  logic [127:0] out_state_w  [3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  aes_mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_SUPPORT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .out_state(out_state_w[0]), .busy(busy_w[0]));

  aes_mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_SUPPORT(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .out_state(out_state_w[1]), .busy(busy_w[1]));

  aes_mix_columns_engine #(.COLS_PER_CYCLE(4), .INV_SUPPORT(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .out_state(out_state_w[2]), .busy(busy_w[2]));

  // Generic GF(2^8) product: carry-less multiply then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[k], s[127 - 8*(4*c + (i + k) % 4) -: 8]);
        r[127 - 8*(4*c + i) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on instance d; inputs are scrambled after acceptance.
  task automatic run_op(input int d, input logic [127:0] s, input logic inv,
                        input logic [127:0] exp, input int lat, input int hold,
                        input string tag);
    int n;
    in_state   = s;
    in_inverse = inv;
    in_valid[d] = 1'b1;
    check({tag, "_in_ready"}, 128'(in_ready_w[d]), 128'd1);
    tick();
    in_valid[d] = 1'b0;
    in_state    = {$urandom, $urandom, $urandom, $urandom};
    in_inverse  = ~inv;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1 && lat > 1) check({tag, "_busy"}, 128'(busy_w[d]), 128'd1);
    end while (!out_valid_w[d] && n < 20);
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_data"}, out_state_w[d], exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_data"}, out_state_w[d], exp);
      check({tag, "_hold_ready"}, 128'({in_ready_w[d], out_valid_w[d]}), 128'b01);
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check({tag, "_back_idle"}, 128'({in_ready_w[d], out_valid_w[d]}), 128'b10);
  endtask

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_COLI  = 128'hd4d4d4d5_2d26314c_00000000_00000000;
  localparam logic [127:0] V_COLO  = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] q [$];
    logic [127:0] s, mid;
    int accepted, cycles, spurious;

    rst = 1'b0;
    in_state = '0;
    in_inverse = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    #3;
    check("reset_in_ready", 128'(in_ready_w[0]), 128'd1);
    check("reset_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("reset_busy", 128'(busy_w[0]), 128'd0);
    check("reset_out_state", out_state_w[0], 128'h0);
    tick();
    rst = 1'b1;

    // Directed vectors, including backpressure hold and INV_SUPPORT=0 behaviour.
    run_op(0, V_PLAIN, 1'b0, V_MIXED, 4, 10, "fwd_c1");
    run_op(0, V_MIXED, 1'b1, V_PLAIN, 4, 0, "inv_c1");
    run_op(0, V_COLI, 1'b0, V_COLO, 4, 2, "colorder_c1");
    run_op(1, V_PLAIN, 1'b0, V_MIXED, 2, 0, "fwd_c2");
    run_op(2, V_PLAIN, 1'b0, V_MIXED, 1, 3, "fwd_c4");
    run_op(1, V_PLAIN, 1'b1, V_MIXED, 2, 0, "noinv_c2");
    run_op(2, V_MIXED, 1'b1, V_PLAIN, 1, 0, "inv_c4");

    // Reset two cycles after acceptance.
    in_state = V_PLAIN; in_inverse = 1'b0; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("rst_busy_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("rst_busy_out_state", out_state_w[0], 128'h0);
    check("rst_busy_in_ready", 128'(in_ready_w[0]), 128'd1);
    check("rst_busy_busy", 128'(busy_w[0]), 128'd0);
    tick();
    rst = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      spurious += int'(out_valid_w[0]);
    end
    check("rst_busy_no_spurious", 128'(spurious), 128'd0);

    // Reset while the result is waiting in DONE.
    in_state = V_COLI; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_done_pre_valid", 128'(out_valid_w[0]), 128'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_done_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("rst_done_out_state", out_state_w[0], 128'h0);
    tick();
    rst = 1'b1;
    run_op(0, V_COLI, 1'b0, V_COLO, 4, 0, "after_reset");

    // Forward then inverse through the hardware restores the original.
    for (int i = 0; i < 4; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_op(0, s, 1'b0, ref_mix(s, 1'b0), 4, 0, "rt_fwd");
      mid = out_state_w[0];
      run_op(2, mid, 1'b1, s, 1, 0, "rt_inv");
    end

    // Random traffic with random handshakes against a scoreboard.
    accepted = 0;
    cycles = 0;
    while ((accepted < 1000 || q.size() != 0) && cycles < 40000) begin
      in_valid[0]  = (accepted < 1000) && ($urandom_range(0, 1) == 1);
      out_ready[0] = ($urandom_range(0, 1) == 1);
      in_state     = {$urandom, $urandom, $urandom, $urandom};
      in_inverse   = ($urandom_range(0, 1) == 1);
      if (out_valid_w[0] && out_ready[0]) begin
        if (q.size() == 0) check("rand_spurious", 128'(out_valid_w[0]), 128'd0);
        else check("rand_data", out_state_w[0], q.pop_front());
      end
      if (in_valid[0] && in_ready_w[0]) begin
        q.push_back(ref_mix(in_state, in_inverse));
        accepted++;
      end
      tick();
      cycles++;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("rand_accepted", 128'(accepted), 128'd1000);
    check("rand_drained", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_mix_columns_engine.md
AES_MIX_COLUMNS_ENGINE -- requirements
Module: aes_mix_columns_engine

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, meaning the number of state columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 The block SHALL have parameter INV_SUPPORT, default 1, meaning that InvMixColumns hardware is present (1) or absent (0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input state is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-007 The block SHALL have port in_state, input, 128 bits: byte k = in_state[127-8k -: 8], and column c = bytes 4c..4c+3, with byte 4c as row 0.
REQ-008 The block SHALL have port in_inverse, input, 1 bit: 1 selects InvMixColumns; it is sampled at acceptance.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_state, output, 128 bits: the result, in the same byte layout as in_state.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in state BUSY.

Function
REQ-013 The FSM SHALL have the states IDLE, BUSY and DONE, and SHALL enter IDLE on reset.
REQ-014 in_ready SHALL be 1 only in IDLE, decoded from the state register alone with no combinational path from out_ready.
REQ-015 An acceptance SHALL be in_valid & in_ready on a rising edge; it latches in_state and in_inverse, clears the column counter, and moves the FSM to BUSY.
REQ-016 When INV_SUPPORT=0, in_inverse SHALL be ignored and every state treated as forward MixColumns.
REQ-017 In BUSY, each cycle SHALL transform COLS_PER_CYCLE columns, in ascending column order starting at column 0, and write them into the result register.
REQ-018 The column counter SHALL be 2 bits wide, advance by COLS_PER_CYCLE each cycle, and wrap to 0 after the last group.
REQ-019 The FSM SHALL move from BUSY to DONE on the cycle that processes column 3, so out_valid rises exactly 4/COLS_PER_CYCLE cycles after acceptance (4, 2 or 1 cycles).
REQ-020 Multiplication by 2 SHALL be implemented as a left shift by 1, XORed with 8'h1b when the input MSB was 1; all arithmetic is GF(2^8) with XOR as addition.
REQ-021 The forward column result SHALL be r_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3), with indices taken mod 4.
REQ-022 The inverse column result SHALL be r_i = 0e*a_i ^ 0b*a_(i+1) ^ 0d*a_(i+2) ^ 09*a_(i+3), built only from repeated multiply-by-2 and XOR.
REQ-023 In DONE, out_valid SHALL be 1 and out_state SHALL be held stable until out_valid & out_ready.
REQ-024 On that output handshake the FSM SHALL return to IDLE; no new state is accepted in the same cycle, so the minimum period is 4/COLS_PER_CYCLE+2 cycles.
REQ-025 in_state and in_inverse changing while the FSM is in BUSY or DONE SHALL NOT affect the result in progress.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-027 out_state SHALL show partially updated content during BUSY, and consumers SHALL qualify it with out_valid only.

Reset
REQ-028 Asserting rst low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, out_state=128'h0 and the column counter to 0.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL discard the operation in progress, and no out_valid pulse SHALL follow.
REQ-030 After rst is deasserted, the first rising edge SHALL be able to accept a state.

Verification
REQ-031 Forward test: in_state = db135345_f20a225c_01010101_c6c6c6c6 with in_inverse=0 -> out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising 4 cycles after acceptance when COLS_PER_CYCLE=1.
REQ-032 Inverse test: in_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 with in_inverse=1 and INV_SUPPORT=1 -> out_state = db135345_f20a225c_01010101_c6c6c6c6.
REQ-033 Latency and backpressure test: run the REQ-031 vector for COLS_PER_CYCLE = 1, 2 and 4 -> latency is 4, 2 and 1 cycles; then hold out_ready=0 for 10 cycles -> out_state is stable and in_ready=0 throughout.
REQ-034 Column ordering test: in_state = d4d4d4d5_2d26314c_00000000_00000000 -> out_state = d5d5d7d6_4d7ebdf8_00000000_00000000.
REQ-035 Reset test: assert rst low 2 cycles after acceptance -> out_valid=0, out_state=0 and in_ready=1 immediately, with no spurious out_valid afterwards.
REQ-036 Random test: 1000 random states with random mode, in_valid and out_ready -> every output matches the reference model, and forward then inverse returns the original state.
